mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Arbitrates four 16-bit requesters onto one shared datapath port and drives the 2-bit select for the four-way operand/writeback mux.
- Uses round-robin priority and grants bursts, with a bounded hold count so no requester can starve the others.
- Captures the selected word into a registered output with a valid/ready handshake toward the consumer (ALU operand latch or register-file write port).

Parameters:
- WIDTH, 16, data width of each requester input and of out.
- MAX_HOLD, 4, maximum beats accepted per grant before forced rotation (legal range 1..15).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  4  per-requester request; bit i = requester i has a valid word on in(i+1).
- last  in  4  per-requester end-of-burst flag, qualified by req.
- in1  in  WIDTH  requester 0 data.
- in2  in  WIDTH  requester 1 data.
- in3  in  WIDTH  requester 2 data.
- in4  in  WIDTH  requester 3 data.
- out_ready  in  1  consumer can accept out this cycle.
- grant  out  4  one-hot owner of the port; all zero when idle.
- ack  out  4  one-hot, one-cycle pulse: the owner's current word was captured, so the owner advances.
- op  out  2  mux select (00→in1, 01→in2, 10→in3, 11→in4); holds its last value when idle.
- out  out  WIDTH  registered selected word.
- out_valid  out  1  out holds an unconsumed word.
- busy  out  1  FSM is in GRANT.

Behaviour:
Reset (asynchronous, reset=0):
- state=IDLE, grant=0, ack=0, op=00, out=0, out_valid=0, busy=0.
- Round-robin pointer rr_ptr=0, meaning requester 0 has highest priority.
- Beat counter cnt=0.
- Reset asserted mid-burst aborts the burst; the word in out is discarded.

FSM state IDLE:
- If req!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo 4.
- On the next edge: grant←onehot(winner), op←winner, cnt←0, state←GRANT.
- Grant is therefore visible 1 cycle after req rises.

FSM state GRANT (owner g = op):
- Capture condition cap = req[g] & (!out_valid | out_ready).
- On cap:
  - out←selected input, out_valid←1, ack[g]=1 in that same cycle (combinational from cap).
  - cnt←cnt+1.
- out_valid←0 when out_ready & out_valid & !cap.
- Release when any of these holds: cap & last[g]; cap & cnt==MAX_HOLD-1; !req[g] (requester withdrew).
- On release at the edge: grant←0, rr_ptr←(g+1) mod 4, state←IDLE.
- out_valid is unaffected by release, so the final word stays valid until consumed.

Timing and throughput:
- Capture latency is 1 cycle: the word captured on edge N appears on out after edge N.
- With out_ready held high, throughput is 1 word/cycle within a burst.
- IDLE costs one bubble cycle between bursts.

Boundary conditions:
- Simultaneous requests: round-robin order only; a requester just released is lowest priority next.
- MAX_HOLD=1: each grant moves exactly one word.
- Backpressure (out_valid=1, out_ready=0): no capture, no ack, cnt frozen, owner keeps grant.
- last asserted with req low: ignored.
- cnt width is 4 bits; cnt never wraps because release fires at MAX_HOLD-1.
- ack is never asserted outside GRANT; grant is never multi-hot.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=1'b0, GRANT=1'b1.
  - Select encodings SEL_IN1..SEL_IN4 (2'b00..2'b11), shared with the four-way mux.
  - Width constant DATA_W=16.
- One sub-module: rr_pick4, a combinational 4-input round-robin picker.
  - Inputs: req[3:0], rr_ptr[1:0].
  - Outputs: winner[1:0], any.
  - Reusable by other arbiters in the processor.

Test Plan:
- Single burst: req=0001, in1=16'hA5A5 constant, last on 3rd ack, out_ready=1 → grant=0001 at cycle 1, acks at cycles 1-3, out=A5A5 valid cycles 2-4, then IDLE, rr_ptr=1.
- Fairness: req=1111 held, last always 1 → grant sequence 0001,0010,0100,1000,0001 with one idle cycle between each; op=00,01,10,11,00.
- Hold limit: MAX_HOLD=4, req=0100 held, last=0 → exactly 4 acks, then release; regrant to requester 2 after one IDLE cycle (it is the only requester).
- Backpressure: mid-burst set out_ready=0 for 3 cycles → out and out_valid frozen, no ack, cnt unchanged; resume with no lost or duplicated word (check the in2 sequence 1,2,3,4 arrives in order).
- Withdrawal: owner drops req after 2 beats → release next edge with no ack; next requester is granted.
- Async reset mid-burst: pull reset low between edges → all outputs 0 immediately; after release, req=1000 is granted with rr_ptr starting at 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin operand/writeback arbiter.
// Holds the FSM encoding, the mux select codes and the one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_IN1 = 2'b00;
    localparam logic [1:0] SEL_IN2 = 2'b01;
    localparam logic [1:0] SEL_IN3 = 2'b10;
    localparam logic [1:0] SEL_IN4 = 2'b11;

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        logic [3:0] v;
        case (sel)
            SEL_IN1: v = 4'b0001;
            SEL_IN2: v = 4'b0010;
            SEL_IN3: v = 4'b0100;
            SEL_IN4: v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle of the four-way arbiter.
// The slave side is the arbiter itself; the master side drives requests and ready.
interface mux4_rr_arbiter_if
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [3:0]       req;
    logic [3:0]       last;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic             out_ready;
    logic [3:0]       grant;
    logic [3:0]       ack;
    logic [1:0]       op;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output req, last, in1, in2, in3, in4, out_ready,
        input  grant, ack, op, out, out_valid, busy
    );

    modport slave (
        input  req, last, in1, in2, in3, in4, out_ready,
        output grant, ack, op, out, out_valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or after rr_ptr.
// Reusable by any arbiter that keeps its own pointer.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_rr_ptr,
    output logic [1:0] o_winner,
    output logic       o_any
);

    // Scan from farthest to nearest offset so the nearest set request wins.
    always_comb begin
        logic [1:0] w_idx;
        w_idx    = i_rr_ptr;
        o_winner = i_rr_ptr;
        o_any    = |i_req;
        for (int k = 3; k >= 0; k--) begin
            w_idx    = i_rr_ptr + 2'(k);
            o_winner = i_req[w_idx] ? w_idx : o_winner;
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter for four requesters onto one registered datapath port.
// Bursts end on last, on the hold limit, or when the owner withdraws its request.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             reset,
    mux4_rr_arbiter_if.slave bus
);

    state_t           r_state;
    logic [3:0]       r_grant;
    logic [1:0]       r_op;
    logic [3:0]       r_cnt;
    logic [1:0]       r_rr_ptr;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    state_t           w_state_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_op_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [1:0]       w_rr_ptr_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_out_valid_nxt;
    logic [3:0]       w_ack;
    logic [WIDTH-1:0] w_sel_data;
    logic [1:0]       w_winner;
    logic             w_any;
    logic             w_cap;
    logic             w_release;

    rr_pick4 u_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Four-way operand mux driven by the registered select.
    always_comb begin
        case (r_op)
            SEL_IN1: w_sel_data = bus.in1;
            SEL_IN2: w_sel_data = bus.in2;
            SEL_IN3: w_sel_data = bus.in3;
            SEL_IN4: w_sel_data = bus.in4;
            default: w_sel_data = bus.in1;
        endcase
    end

    assign w_cap     = (r_state == ST_GRANT) & bus.req[r_op] & (~r_out_valid | bus.out_ready);
    assign w_release = (w_cap & bus.last[r_op])
                     | (w_cap & (r_cnt == 4'(MAX_HOLD - 1)))
                     | ~bus.req[r_op];

    // Next-state and datapath update; consumer drain applies in every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_op_nxt        = r_op;
        w_cnt_nxt       = r_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_out_nxt       = r_out;
        w_out_valid_nxt = (r_out_valid & bus.out_ready & ~w_cap) ? 1'b0 : r_out_valid;
        w_ack           = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = onehot4(w_winner);
                    w_op_nxt    = w_winner;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_grant_nxt = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (w_cap) begin
                    w_out_nxt       = w_sel_data;
                    w_out_valid_nxt = 1'b1;
                    w_cnt_nxt       = r_cnt + 4'd1;
                    w_ack           = onehot4(r_op);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = 4'b0000;
                    w_rr_ptr_nxt = r_op + 2'd1;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= 4'b0000;
            r_op        <= SEL_IN1;
            r_cnt       <= 4'd0;
            r_rr_ptr    <= 2'd0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ack       = w_ack;
    assign bus.op        = r_op;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state == ST_GRANT);

endmodule
